// File: rtl/axi_read_arbiter_if.sv
// AXI read address / read data channel bundle
// between the read arbiter and the crossbar.
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arvalid, rready,
    input  arready, rid, rdata, rresp,
    input  rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arvalid, rready,
    output arready, rid, rdata, rresp,
    output rlast, rvalid
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter serialising I$, D$ and
// uncached burst reads onto one AXI AR/R pair.
module axi_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*3-1:0]      req_size,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic                      proto_err,
  axi_read_arbiter_if.master        axi
);

  localparam int GW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic              arvalid_q;
  logic [7:0]        beat_cnt;
  logic              perr_q;

  logic              found;
  logic [GW-1:0]     pick;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [2:0]        sel_size;
  logic [NUM_REQ-1:0] gnt_oh;
  logic              unused_rid;

  // Scan upward from the slot after the last
  // owner so every requester gets a turn.
  always_comb begin
    int unsigned idx;
    logic [NUM_REQ-1:0] shr;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    shr   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_grant) + 32'(i);
      if (idx >= 32'(NUM_REQ))
        idx = idx - 32'(NUM_REQ);
      shr = req_valid >> idx;
      if (!found && shr[0]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_len  = req_len[i*LEN_W +: LEN_W];
        sel_size = req_size[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arvalid_q  <= 1'b0;
      beat_cnt   <= '0;
      perr_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            araddr_q  <= sel_addr;
            arlen_q   <= 8'(sel_len);
            arsize_q  <= sel_size;
            beat_cnt  <= '0;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (axi.rvalid) begin
            beat_cnt <= beat_cnt + 8'd1;
            // rlast early or missing on the final
            // beat; the flag is sticky, so later
            // beats cannot change the verdict.
            if (axi.rlast != (beat_cnt == arlen_q))
              perr_q <= 1'b1;
            if (axi.rlast) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_oh = NUM_REQ'(1) << grant;

  assign axi.arid    = 4'(grant);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = (state == DATA);

  assign req_ready =
    (state == ADDR && axi.arready) ? gnt_oh : '0;
  assign rsp_valid =
    (state == DATA && axi.rvalid) ? gnt_oh : '0;
  assign rsp_data  = axi.rdata;
  assign rsp_last  = axi.rlast;
  assign rsp_err   = (axi.rresp != 2'b00);
  assign proto_err = perr_q;

  assign unused_rid = ^axi.rid;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed table,
// reset-abort sequence and randomized traffic.
module tb_axi_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*LW-1:0]   req_len = '0;
  logic [N*3-1:0]    req_size = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              proto_err;

  axi_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) axi();

  axi_read_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW),
    .DATA_W(DW), .LEN_W(LW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_len(req_len),
    .req_size(req_size),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_last(rsp_last),
    .rsp_err(rsp_err),
    .proto_err(proto_err),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rv;
    logic [31:0] addr;
    int          len;
    logic [2:0]  size;
    int          last_at;
    int          err_beat;
    int          ar_wait;
    int          exp_g;
    bit          exp_proto;
  } vec_t;

  vec_t tbl[11];

  int n_chk  = 0;
  int n_fail = 0;

  int         last_g;
  bit         proto_exp;
  logic [31:0] addr_m[N];
  logic [7:0]  len_m[N];
  logic [2:0]  size_m[N];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [31:0] a,
                         input int l,
                         input logic [2:0] s);
    addr_m[i] = a;
    len_m[i]  = 8'(l);
    size_m[i] = s;
    req_addr[i*AW +: AW] = a;
    req_len[i*LW +: LW]  = LW'(l);
    req_size[i*3 +: 3]   = s;
  endtask

  // Reference arbitration: first requesting
  // index after the previous owner, modulo N.
  function automatic int model_pick(
      input logic [2:0] rv, input int lg);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (lg + k) % N;
      if (((rv >> c) & 3'b001) != 3'b000)
        return c;
    end
    return 0;
  endfunction

  // Starts on a falling edge with the DUT idle,
  // ends on the falling edge after the last beat.
  task automatic run_txn(input logic [2:0] rv,
                         input int g,
                         input int last_at,
                         input int err_beat,
                         input int ar_wait,
                         input bit gaps);
    int beat;
    int cyc;
    logic [N-1:0] oh;
    oh = N'(1) << g;
    req_valid = rv;
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    #1;
    chk("idle_arvalid", 64'(axi.arvalid), 64'd0);
    chk("idle_rready", 64'(axi.rready), 64'd0);
    for (int w = 0; w <= ar_wait; w++) begin
      @(negedge clk);
      axi.arready = (w == ar_wait);
      #1;
      chk("arvalid", 64'(axi.arvalid), 64'd1);
      chk("arid", 64'(axi.arid), 64'(g));
      chk("araddr", 64'(axi.araddr), 64'(addr_m[g]));
      chk("arlen", 64'(axi.arlen), 64'(len_m[g]));
      chk("arsize", 64'(axi.arsize), 64'(size_m[g]));
      chk("arburst", 64'(axi.arburst), 64'd1);
      chk("req_ready", 64'(req_ready),
          (w == ar_wait) ? 64'(oh) : 64'd0);
    end
    beat = 0;
    cyc  = 0;
    while (beat <= last_at && cyc < 300) begin
      @(negedge clk);
      axi.arready = 1'b0;
      axi.rvalid  = !(gaps && $urandom_range(0, 2) == 0);
      axi.rdata   = $urandom;
      axi.rid     = 4'($urandom);
      axi.rresp   = (beat == err_beat) ? 2'b10 : 2'b00;
      axi.rlast   = (beat == last_at);
      #1;
      chk("rready", 64'(axi.rready), 64'd1);
      chk("data_arvalid", 64'(axi.arvalid), 64'd0);
      chk("data_req_ready", 64'(req_ready), 64'd0);
      chk("rsp_valid", 64'(rsp_valid),
          axi.rvalid ? 64'(oh) : 64'd0);
      if (axi.rvalid) begin
        chk("rsp_data", 64'(rsp_data), 64'(axi.rdata));
        chk("rsp_last", 64'(rsp_last),
            64'(beat == last_at));
        chk("rsp_err", 64'(rsp_err),
            64'(beat == err_beat));
        beat++;
      end
      cyc++;
    end
    if (cyc >= 300)
      chk("r_timeout", 64'd1, 64'd0);
    @(negedge clk);
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    axi.rresp  = 2'b00;
    req_valid  = '0;
    if (last_at != int'(len_m[g]))
      proto_exp = 1'b1;
    last_g = g;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rv;
    int g;
    int eb;

    tbl[0]  = '{3'b111, 32'h2000_0000, 0, 3'd2, 0, -1, 0, 0, 1'b0};
    tbl[1]  = '{3'b111, 32'h2000_0010, 0, 3'd2, 0, -1, 0, 1, 1'b0};
    tbl[2]  = '{3'b111, 32'h2000_0020, 0, 3'd2, 0, -1, 0, 2, 1'b0};
    tbl[3]  = '{3'b111, 32'h2000_0030, 0, 3'd2, 0, -1, 0, 0, 1'b0};
    tbl[4]  = '{3'b111, 32'h2000_0040, 0, 3'd2, 0, -1, 0, 1, 1'b0};
    tbl[5]  = '{3'b111, 32'h2000_0050, 0, 3'd2, 0, -1, 0, 2, 1'b0};
    tbl[6]  = '{3'b010, 32'h1000_0040, 7, 3'd2, 7, -1, 0, 1, 1'b0};
    tbl[7]  = '{3'b100, 32'h3000_0100, 2, 3'd1, 2, -1, 5, 2, 1'b0};
    tbl[8]  = '{3'b001, 32'h4000_0000, 3, 3'd2, 3,  2, 0, 0, 1'b0};
    tbl[9]  = '{3'b010, 32'h5000_0000, 3, 3'd2, 1, -1, 0, 1, 1'b1};
    tbl[10] = '{3'b100, 32'h6000_0000, 1, 3'd0, 1, -1, 1, 2, 1'b1};

    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rresp   = 2'b00;
    axi.rdata   = '0;
    axi.rid     = '0;
    last_g    = N - 1;
    proto_exp = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", 64'(axi.arvalid), 64'd0);
    chk("rst_arid", 64'(axi.arid), 64'd0);
    chk("rst_araddr", 64'(axi.araddr), 64'd0);
    chk("rst_arlen", 64'(axi.arlen), 64'd0);
    chk("rst_arsize", 64'(axi.arsize), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rready", 64'(axi.rready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);

    @(negedge clk);
    resetn = 1'b1;

    for (int t = 0; t < 11; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i,
                (i == tbl[t].exp_g) ? tbl[t].addr
                  : tbl[t].addr + 32'h100 * 32'(i + 1),
                tbl[t].len, tbl[t].size);
      run_txn(tbl[t].rv, tbl[t].exp_g, tbl[t].last_at,
              tbl[t].err_beat, tbl[t].ar_wait, 1'b0);
      #1;
      chk("tbl_proto_err", 64'(proto_err),
          64'(tbl[t].exp_proto));
    end

    // Reset in the middle of an 8-beat burst.
    set_req(1, 32'h7000_0000, 7, 3'd2);
    req_valid   = 3'b010;
    axi.arready = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    axi.arready = 1'b0;
    req_valid   = '0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 32'hA5A5_0000;
    #1;
    chk("abort_beat0", 64'(rsp_valid), 64'b010);
    @(negedge clk);
    axi.rdata = 32'hA5A5_0001;
    @(negedge clk);
    axi.rdata = 32'hA5A5_0002;
    resetn    = 1'b0;
    #1;
    chk("abort_beat2", 64'(rsp_valid), 64'b010);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("abort_arvalid", 64'(axi.arvalid), 64'd0);
    chk("abort_rready", 64'(axi.rready), 64'd0);
    chk("abort_proto_err", 64'(proto_err), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    axi.rvalid = 1'b0;
    last_g    = N - 1;
    proto_exp = 1'b0;
    set_req(0, 32'h8000_0000, 1, 3'd2);
    set_req(2, 32'h9000_0000, 1, 3'd2);
    run_txn(3'b101, 0, 1, -1, 0, 1'b0);
    #1;
    chk("post_rst_proto", 64'(proto_err), 64'd0);

    // Random traffic against the arbitration model.
    for (int t = 0; t < 40; t++) begin
      rv = 3'($urandom_range(1, 7));
      for (int i = 0; i < N; i++)
        set_req(i, $urandom & 32'hFFFF_FFFC,
                int'($urandom_range(0, 7)),
                3'($urandom_range(0, 2)));
      g  = model_pick(rv, last_g);
      eb = int'($urandom_range(0, 8)) - 1;
      run_txn(rv, g, int'(len_m[g]), eb,
              int'($urandom_range(0, 3)), 1'b1);
      #1;
      chk("rnd_proto_err", 64'(proto_err),
          64'(proto_exp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Round-robin arbiter that shares the single AXI read-address/read-data channel pair among the I-cache refill, D-cache refill and uncached-load requesters. Each requester issues one burst request through a simple valid/ready port. The arbiter serialises the requests onto AR, tracks the burst on R, and steers each beat back to the owning requester. It sits between the cache/uncache controllers and the AXI crossbar, with exactly one read transaction outstanding at a time.

## Interface
Parameters:
- NUM_REQ, default 3: number of requesters. Index 0 = I-cache, 1 = D-cache, 2 = uncache.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
- LEN_W, default 4: width of the per-request burst length field (beats-1).

Ports:
- clk  in  1  clock. Every register updates on its rising edge.
- resetn  in  1  reset; synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request. Held until the matching req_ready.
- req_addr  in  NUM_REQ*ADDR_W  per-requester start address, packed with slice i = requester i.
- req_len  in  NUM_REQ*LEN_W  per-requester beats-1.
- req_size  in  NUM_REQ*3  per-requester AXI size.
- req_ready  out  NUM_REQ  one-cycle pulse to the granted requester on the AR handshake.
- rsp_valid  out  NUM_REQ  beat valid, steered to the owner only.
- rsp_data  out  DATA_W  shared beat data, equal to rdata.
- rsp_last  out  1  last beat, equal to rlast.
- rsp_err  out  1  rresp != 2'b00 on this beat.
- arid  out  4  equals the grant index.
- araddr  out  ADDR_W
- arlen  out  8  zero-extended req_len.
- arsize  out  3
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1
- arready  in  1
- rid  in  4  ignored; only one transaction is ever outstanding.
- rdata  in  DATA_W
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1
- proto_err  out  1  sticky flag for a beat-count mismatch.

## Operation
- FSM states are IDLE, ADDR and DATA.
- IDLE:
  - If any req_valid bit is set, select the first set bit scanning upward, with wraparound, from last_grant+1.
  - Register grant, araddr, arlen and arsize from that requester's slices.
  - Clear the beat counter and go to ADDR.
  - With no request, remain in IDLE.
- ADDR:
  - arvalid=1, with all AR fields stable.
  - When arvalid && arready: pulse req_ready[grant] for that cycle and go to DATA.
  - Requester inputs are not re-sampled in this state.
- DATA:
  - rready=1.
  - rsp_valid[grant]=rvalid. Every other rsp_valid bit is 0.
  - Each beat (rvalid) increments the 8-bit beat counter.
  - On rvalid && rlast: set last_grant=grant and go to IDLE.
- Protocol check, which sets proto_err until reset:
  - rlast arrives on a beat whose index != arlen.
  - A beat with index == arlen arrives without rlast. In this case the counter stops checking, and the FSM still waits for rlast.
- rsp_err is a per-beat indication only. It does not affect sequencing.
- Outside DATA: rready=0, all rsp_valid=0, and R inputs are ignored.
- Reset values:
  - State IDLE, arvalid 0, req_ready 0, rready 0, rsp_valid 0, proto_err 0.
  - grant 0, araddr 0, arlen 0, arsize 0, beat counter 0.
  - last_grant = NUM_REQ-1, so requester 0 wins the first arbitration.
- Reset mid-burst returns to IDLE immediately. Remaining R beats from the aborted burst are the interconnect's concern, since both sides are reset together.

## Timing
- arvalid, araddr, arlen, arsize and arid are registered outputs. req_ready, rready, rsp_valid, rsp_data, rsp_last and rsp_err are combinational from state and R inputs.
- Request latency: req_valid seen in IDLE at cycle T gives arvalid=1 at T+1. With arready=1, req_ready pulses at T+1 and DATA is entered at T+2.
- Back-to-back: the rlast beat is accepted at cycle T, IDLE at T+1, and the next arvalid at T+2. The minimum bus gap is 2 cycles.
- arvalid stays asserted until arready, regardless of req_valid dropping. Dropping req_valid before req_ready is a requester error and is not supported.
- Simultaneous requests are resolved purely by round-robin. A requester that keeps req_valid asserted is served within NUM_REQ transactions.
- The arbitration decision is made only in IDLE. A request that arrives while another burst is in flight waits.

## Test plan
- **Single request.** After reset, req_valid=3'b010, addr 0x1000_0040, len 7, size 2, arready=1.
  - arvalid at T+1, araddr 0x1000_0040, arlen 7, arid 1, req_ready=3'b010 at T+1.
  - 8 R beats (last with rlast) give rsp_valid=3'b010 on each, and IDLE afterwards.
- **Round-robin fairness.** req_valid=3'b111 held constantly with 1-beat bursts.
  - Grant order is 0,1,2,0,1,2.
  - arvalid pulses for consecutive transactions are 2 idle cycles apart at minimum.
- **Backpressure.** arready=0 for 5 cycles with a request from requester 2.
  - arvalid and AR fields stay stable for all 5 cycles.
  - req_ready stays 0 until the handshake cycle, then pulses exactly once.
- **Error and protocol.**
  - rresp=2'b10 on beat 3 of 4 gives rsp_err=1 on that beat only.
  - A separate burst with len 3 and rlast on beat 1 gives proto_err=1 held until reset, and the FSM returns to IDLE.
- **Reset mid-burst.** resetn=0 during beat 2 of an 8-beat burst.
  - Next cycle: IDLE, arvalid 0, rready 0, proto_err 0.
  - With req_valid=3'b101 after reset, requester 0 is granted first.
